// File: rtl/udatapath_pipe_pkg.sv
// Shared constants for the two-stage micro-architecture datapath:
// ALU opcodes, PSR bit positions, IR field positions and the condition-code type.
package udatapath_pipe_pkg;

   // ALU opcodes
   localparam int unsigned ALU_ADD    = 0;
   localparam int unsigned ALU_ADDCC  = 1;
   localparam int unsigned ALU_AND    = 2;
   localparam int unsigned ALU_ANDCC  = 3;
   localparam int unsigned ALU_OR     = 4;
   localparam int unsigned ALU_ORCC   = 5;
   localparam int unsigned ALU_ORNCC  = 6;
   localparam int unsigned ALU_SRL    = 7;
   localparam int unsigned ALU_SLL    = 8;
   localparam int unsigned ALU_INC    = 9;
   localparam int unsigned ALU_PASS_A = 10;

   // PSR bit positions inside the exported {N,Z,V,C} nibble
   localparam int unsigned PSR_N = 3;
   localparam int unsigned PSR_Z = 2;
   localparam int unsigned PSR_V = 1;
   localparam int unsigned PSR_C = 0;

   // IR field positions
   localparam int unsigned IR_REG_FIELD_W = 5;
   localparam int unsigned IR_RD_MSB      = 29;
   localparam int unsigned IR_RD_LSB      = 25;
   localparam int unsigned IR_RS1_MSB     = 18;
   localparam int unsigned IR_RS1_LSB     = 14;
   localparam int unsigned IR_RS2_MSB     = 4;
   localparam int unsigned IR_RS2_LSB     = 0;
   localparam int unsigned IR_I_BIT       = 13;
   localparam int unsigned IR_OP_HI_MSB   = 31;
   localparam int unsigned IR_OP_HI_LSB   = 30;
   localparam int unsigned IR_OP_LO_MSB   = 24;
   localparam int unsigned IR_OP_LO_LSB   = 19;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } nzvc_t;

   // Opcodes that update the PSR
   function automatic logic is_cc_op(input int unsigned op);
      return op inside {ALU_ADDCC, ALU_ANDCC, ALU_ORCC, ALU_ORNCC};
   endfunction

endpackage

// File: rtl/udatapath_pipe_alu.sv
// Combinational ALU for udatapath_pipe.
// Ports: sel (opcode), a/b (operands), result_c (wrap-around result),
//        nzvc_c (condition codes for this op), set_flags_c (op updates the PSR).
module udatapath_pipe_alu
   import udatapath_pipe_pkg::*;
#(
   parameter int unsigned DATAWIDTH_BUS           = 32,
   parameter int unsigned DATAWIDTH_ALU_SELECTION = 4
)(
   input  logic [DATAWIDTH_ALU_SELECTION-1:0] sel,
   input  logic [DATAWIDTH_BUS-1:0]           a,
   input  logic [DATAWIDTH_BUS-1:0]           b,
   output logic [DATAWIDTH_BUS-1:0]           result_c,
   output nzvc_t                              nzvc_c,
   output logic                               set_flags_c
);

   localparam int unsigned W = DATAWIDTH_BUS;

   int unsigned op;
   logic [W-1:0] add_b;
   logic [W:0]   sum;
   logic         is_add;

   // Shared adder serves ADD, ADDCC and INC; V/C only meaningful for those
   always_comb begin
      op          = 32'(sel);
      add_b       = (op == ALU_INC) ? W'(1) : b;
      sum         = {1'b0, a} + {1'b0, add_b};
      is_add      = op inside {ALU_ADD, ALU_ADDCC, ALU_INC};
      result_c    = '0;
      case (op)
         ALU_ADD, ALU_ADDCC, ALU_INC: result_c = sum[W-1:0];
         ALU_AND, ALU_ANDCC:          result_c = a & b;
         ALU_OR, ALU_ORCC:            result_c = a | b;
         ALU_ORNCC:                   result_c = a | ~b;
         ALU_SRL:                     result_c = a >> b[4:0];
         ALU_SLL:                     result_c = a << b[4:0];
         ALU_PASS_A:                  result_c = a;
         default:                     result_c = '0;
      endcase
      nzvc_c.n    = result_c[W-1];
      nzvc_c.z    = (result_c == '0);
      nzvc_c.v    = is_add && (a[W-1] == add_b[W-1]) && (result_c[W-1] != a[W-1]);
      nzvc_c.c    = is_add && sum[W];
      set_flags_c = is_cc_op(op);
   end

endmodule

// File: rtl/udatapath_pipe.sv
// Two-stage micro-architecture datapath: EX (operand read + ALU, registered
// into WB) and WB (register-file write, waiting on data memory for loads).
// Optional macro UDATAPATH_PIPE_FORWARD_EN: bypass the WB value to EX reads;
// without it a matching read stalls the handshake until the write lands.
// Ports:
//   uDataPathPipe_CLOCK_50 / _RESET_InLow      clock, async active-low reset
//   _IR_Load_In / _IR_Data_In                  instruction register load
//   _Uop_Valid_In / _Uop_Ready_Out             micro-op handshake
//   _ALU_Selection_In, _MUX_{A,B,C}_MIR(_Selector), _RegWrite_In, _MemRead_In
//   _DataMemory_Data_In / _DataMemory_Valid_In load return
//   _Result_Out / _Result_Valid_Out            WB value and completion pulse
//   _Reg_IR_OP, _Reg_IR_IR13                   IR fields for control
//   _PSR_NZVC_Out                              registered condition codes
module udatapath_pipe
   import udatapath_pipe_pkg::*;
#(
   parameter int unsigned DATAWIDTH_BUS               = 32,
   parameter int unsigned REG_COUNT                   = 32,
   parameter int unsigned DATAWIDTH_BUS_REG_MIR_FIELD = 6,
   parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4,
   parameter int unsigned DATAWIDTH_BUS_REG_IR_OP     = 8
)(
   input  logic                                   uDataPathPipe_CLOCK_50,
   input  logic                                   uDataPathPipe_RESET_InLow,
   input  logic                                   uDataPathPipe_IR_Load_In,
   input  logic [DATAWIDTH_BUS-1:0]               uDataPathPipe_IR_Data_In,
   input  logic                                   uDataPathPipe_Uop_Valid_In,
   output logic                                   uDataPathPipe_Uop_Ready_Out,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0]     uDataPathPipe_ALU_Selection_In,
   input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uDataPathPipe_MUX_A_MIR,
   input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uDataPathPipe_MUX_B_MIR,
   input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uDataPathPipe_MUX_C_MIR,
   input  logic                                   uDataPathPipe_MUX_A_MIR_Selector,
   input  logic                                   uDataPathPipe_MUX_B_MIR_Selector,
   input  logic                                   uDataPathPipe_MUX_C_MIR_Selector,
   input  logic                                   uDataPathPipe_RegWrite_In,
   input  logic                                   uDataPathPipe_MemRead_In,
   input  logic [DATAWIDTH_BUS-1:0]               uDataPathPipe_DataMemory_Data_In,
   input  logic                                   uDataPathPipe_DataMemory_Valid_In,
   output logic [DATAWIDTH_BUS-1:0]               uDataPathPipe_Result_Out,
   output logic                                   uDataPathPipe_Result_Valid_Out,
   output logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     uDataPathPipe_Reg_IR_OP,
   output logic                                   uDataPathPipe_Reg_IR_IR13,
   output logic [3:0]                             uDataPathPipe_PSR_NZVC_Out
);

   localparam int unsigned DW         = DATAWIDTH_BUS;
   localparam int unsigned AW         = DATAWIDTH_BUS_REG_MIR_FIELD;
   localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);

   logic          clk;
   logic          rst_n;
   assign clk   = uDataPathPipe_CLOCK_50;
   assign rst_n = uDataPathPipe_RESET_InLow;

   // Architectural and pipeline state
   logic [DW-1:0] ir;
   logic [DW-1:0] rf [REG_COUNT];
   nzvc_t         psr;
   logic          wb_valid;
   logic          wb_regwrite;
   logic          wb_memread;
   logic [DW-1:0] wb_result;
   logic [AW-1:0] wb_c;

   logic [AW-1:0] addr_a_c, addr_b_c, addr_c_c;
   logic [DW-1:0] opnd_a_c, opnd_b_c, wb_value_c, alu_result_c;
   nzvc_t         alu_nzvc_c;
   logic          alu_set_flags_c;
   logic          wb_done_c, load_wait_c, wb_fwd_c, accept_c, ready_c;

   // Address names a real, writable register (not r0, not beyond the file)
   function automatic logic in_file(input logic [AW-1:0] addr);
      return (addr != '0) && (32'(addr) < REG_COUNT);
   endfunction

   // Operand address muxes; IR fields are zero-extended to the MIR width
   assign addr_a_c = uDataPathPipe_MUX_A_MIR_Selector ? uDataPathPipe_MUX_A_MIR
                                                      : AW'(ir[IR_RS1_MSB:IR_RS1_LSB]);
   assign addr_b_c = uDataPathPipe_MUX_B_MIR_Selector ? uDataPathPipe_MUX_B_MIR
                                                      : AW'(ir[IR_RS2_MSB:IR_RS2_LSB]);
   assign addr_c_c = uDataPathPipe_MUX_C_MIR_Selector ? uDataPathPipe_MUX_C_MIR
                                                      : AW'(ir[IR_RD_MSB:IR_RD_LSB]);

   // WB-stage status; a load completes only in the memory-valid cycle
   assign load_wait_c = wb_valid && wb_memread && !uDataPathPipe_DataMemory_Valid_In;
   assign wb_done_c   = wb_valid && (!wb_memread || uDataPathPipe_DataMemory_Valid_In);
   assign wb_value_c  = (wb_memread && uDataPathPipe_DataMemory_Valid_In)
                        ? uDataPathPipe_DataMemory_Data_In : wb_result;
   assign wb_fwd_c    = wb_valid && wb_regwrite && in_file(wb_c);

   // Operand read: out-of-file and r0 read zero, WB bypass overrides the file
   always_comb begin
      opnd_a_c = '0;
      opnd_b_c = '0;
      if (in_file(addr_a_c)) opnd_a_c = rf[addr_a_c[REG_ADDR_W-1:0]];
      if (in_file(addr_b_c)) opnd_b_c = rf[addr_b_c[REG_ADDR_W-1:0]];
`ifdef UDATAPATH_PIPE_FORWARD_EN
      if (wb_fwd_c && (addr_a_c == wb_c)) opnd_a_c = wb_value_c;
      if (wb_fwd_c && (addr_b_c == wb_c)) opnd_b_c = wb_value_c;
`endif
   end

`ifdef UDATAPATH_PIPE_FORWARD_EN
   assign ready_c = !load_wait_c;
`else
   // Without bypass a read of the pending destination waits for the write
   logic hazard_c;
   assign hazard_c = wb_fwd_c && ((addr_a_c == wb_c) || (addr_b_c == wb_c));
   assign ready_c  = !load_wait_c && !hazard_c;
`endif

   assign accept_c = uDataPathPipe_Uop_Valid_In && ready_c;

   udatapath_pipe_alu #(
      .DATAWIDTH_BUS           (DW),
      .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
   ) u_alu (
      .sel         (uDataPathPipe_ALU_Selection_In),
      .a           (opnd_a_c),
      .b           (opnd_b_c),
      .result_c    (alu_result_c),
      .nzvc_c      (alu_nzvc_c),
      .set_flags_c (alu_set_flags_c)
   );

   // IR, PSR and EX->WB pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir          <= '0;
         psr         <= '0;
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_memread  <= 1'b0;
         wb_result   <= '0;
         wb_c        <= '0;
      end else begin
         if (uDataPathPipe_IR_Load_In) ir <= uDataPathPipe_IR_Data_In;
         if (accept_c) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= uDataPathPipe_RegWrite_In;
            wb_memread  <= uDataPathPipe_MemRead_In;
            wb_result   <= alu_result_c;
            wb_c        <= addr_c_c;
            if (alu_set_flags_c) psr <= alu_nzvc_c;
         end else if (wb_done_c) begin
            // Keep the completed value visible once the stage drains
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_memread  <= 1'b0;
            wb_result   <= wb_value_c;
         end
      end
   end

   // Register file write; r0 and out-of-file destinations are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) rf[REG_ADDR_W'(i)] <= '0;
      end else if (wb_done_c && wb_regwrite && in_file(wb_c)) begin
         rf[wb_c[REG_ADDR_W-1:0]] <= wb_value_c;
      end
   end

   assign uDataPathPipe_Uop_Ready_Out    = ready_c;
   assign uDataPathPipe_Result_Out       = wb_value_c;
   assign uDataPathPipe_Result_Valid_Out = wb_done_c;
   assign uDataPathPipe_Reg_IR_OP        = DATAWIDTH_BUS_REG_IR_OP'({ir[IR_OP_HI_MSB:IR_OP_HI_LSB],
                                                                     ir[IR_OP_LO_MSB:IR_OP_LO_LSB]});
   assign uDataPathPipe_Reg_IR_IR13      = ir[IR_I_BIT];
   assign uDataPathPipe_PSR_NZVC_Out[PSR_N] = psr.n;
   assign uDataPathPipe_PSR_NZVC_Out[PSR_Z] = psr.z;
   assign uDataPathPipe_PSR_NZVC_Out[PSR_V] = psr.v;
   assign uDataPathPipe_PSR_NZVC_Out[PSR_C] = psr.c;

   // IR bits between rs2 and the immediate flag are not decoded here
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[IR_I_BIT-1:IR_RS2_MSB+1];

endmodule

// File: tb/tb_udatapath_pipe.sv
// Directed scoreboard bench for udatapath_pipe: each accepted micro-op pushes
// its expected WB value; every Result_Valid_Out pulse pops and compares.
module tb_udatapath_pipe;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_ADDCC  = 4'd1;
   localparam logic [3:0] OP_ORCC   = 4'd5;
   localparam logic [3:0] OP_ORNCC  = 4'd6;
   localparam logic [3:0] OP_SRL    = 4'd7;
   localparam logic [3:0] OP_SLL    = 4'd8;
   localparam logic [3:0] OP_INC    = 4'd9;
   localparam logic [3:0] OP_PASS_A = 4'd10;
   localparam logic [3:0] OP_BAD    = 4'd15;

`ifdef UDATAPATH_PIPE_FORWARD_EN
   localparam int DEP_STALL = 0;
`else
   localparam int DEP_STALL = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ir_load;
   logic [31:0] ir_data;
   logic        uop_valid;
   logic        uop_ready;
   logic [3:0]  alu_sel;
   logic [5:0]  mir_a, mir_b, mir_c;
   logic        sel_a, sel_b, sel_c;
   logic        reg_write, mem_read;
   logic [31:0] mem_data;
   logic        mem_valid;
   logic [31:0] result;
   logic        result_valid;
   logic [7:0]  ir_op;
   logic        ir13;
   logic [3:0]  psr;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] sbq[$];

   always #5 clk = ~clk;

   udatapath_pipe dut (
      .uDataPathPipe_CLOCK_50           (clk),
      .uDataPathPipe_RESET_InLow        (rst_n),
      .uDataPathPipe_IR_Load_In         (ir_load),
      .uDataPathPipe_IR_Data_In         (ir_data),
      .uDataPathPipe_Uop_Valid_In       (uop_valid),
      .uDataPathPipe_Uop_Ready_Out      (uop_ready),
      .uDataPathPipe_ALU_Selection_In   (alu_sel),
      .uDataPathPipe_MUX_A_MIR          (mir_a),
      .uDataPathPipe_MUX_B_MIR          (mir_b),
      .uDataPathPipe_MUX_C_MIR          (mir_c),
      .uDataPathPipe_MUX_A_MIR_Selector (sel_a),
      .uDataPathPipe_MUX_B_MIR_Selector (sel_b),
      .uDataPathPipe_MUX_C_MIR_Selector (sel_c),
      .uDataPathPipe_RegWrite_In        (reg_write),
      .uDataPathPipe_MemRead_In         (mem_read),
      .uDataPathPipe_DataMemory_Data_In (mem_data),
      .uDataPathPipe_DataMemory_Valid_In(mem_valid),
      .uDataPathPipe_Result_Out         (result),
      .uDataPathPipe_Result_Valid_Out   (result_valid),
      .uDataPathPipe_Reg_IR_OP          (ir_op),
      .uDataPathPipe_Reg_IR_IR13        (ir13),
      .uDataPathPipe_PSR_NZVC_Out       (psr)
   );

   // Memory-valid is a single-cycle strobe from the bench's point of view
   task automatic tick();
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at every falling edge: consume a completed WB value
   task automatic mon();
      logic [31:0] e;
      if (result_valid === 1'b1) begin
         n_assert++;
         assert (sbq.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_result: observed %h, expected no result pulse", result);
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wb_result", result, e);
         end
      end
   endtask

   // Present a uop and hold it until accepted; leaves uop_valid high
   task automatic issue(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] c, input logic sa, input logic sb, input logic sc,
                        input logic rw, input logic mr, input logic [31:0] exp,
                        output int stalls);
      bit ok;
      ok = 1'b0;
      stalls = 0;
      uop_valid = 1'b1; alu_sel = op; mir_a = a; mir_b = b; mir_c = c;
      sel_a = sa; sel_b = sb; sel_c = sc; reg_write = rw; mem_read = mr;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         mon();
         if (uop_ready === 1'b1) begin
            ok = 1'b1;
            sbq.push_back(exp);
         end else begin
            stalls++;
         end
         tick();
      end
      n_assert++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL accept_timeout: observed ready low for %0d cycles, expected acceptance", stalls);
      end
   endtask

   task automatic uop(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] c, input logic rw, input logic [31:0] exp);
      int s;
      issue(op, a, b, c, 1'b1, 1'b1, 1'b1, rw, 1'b0, exp, s);
   endtask

   // Load into register c; memory answers after lat cycles (strobe left pending)
   task automatic load(input logic [5:0] c, input logic [31:0] data, input int lat,
                       output int low);
      int s;
      issue(OP_PASS_A, 6'd0, 6'd0, c, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, data, s);
      uop_valid = 1'b0; mem_read = 1'b0;
      low = 0;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         mon();
         if (uop_ready === 1'b0) low++;
         tick();
      end
      mem_data = data;
      mem_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      uop_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mon();
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int low, s;
      logic [31:0] w1, w2;
      rst_n = 1'b0; ir_load = 1'b0; ir_data = '0; uop_valid = 1'b0; alu_sel = '0;
      mir_a = '0; mir_b = '0; mir_c = '0; sel_a = 1'b1; sel_b = 1'b1; sel_c = 1'b1;
      reg_write = 1'b0; mem_read = 1'b0; mem_data = '0; mem_valid = 1'b0;

      // Reset state
      #2;
      chk("rst_ready", 32'(uop_ready), 32'd1);
      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_psr", 32'(psr), 32'd0);
      chk("rst_ir_op", 32'(ir_op), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      idle(1);

      // Reset mid-load: load to r5 pending, never answered
      issue(OP_PASS_A, 6'd0, 6'd0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, s);
      uop_valid = 1'b0; mem_read = 1'b0;
      idle(2);
      chk("load_pending_ready", 32'(uop_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midload_rst_ready", 32'(uop_ready), 32'd1);
      chk("midload_rst_valid", 32'(result_valid), 32'd0);
      chk("midload_rst_result", result, 32'd0);
      sbq.delete();
      tick(); tick();
      rst_n = 1'b1;
      uop(OP_PASS_A, 6'd5, 6'd0, 6'd0, 1'b0, 32'd0);

      // ADDCC overflow, then ORCC of zeros
      load(6'd1, 32'h7FFF_FFFF, 0, low);
      load(6'd2, 32'h0000_0001, 1, low);
      uop(OP_ADDCC, 6'd1, 6'd2, 6'd7, 1'b1, 32'h8000_0000);
      chk("addcc_psr", 32'(psr), 32'b1010);
      uop(OP_ORCC, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0);
      chk("orcc_psr", 32'(psr), 32'b0100);

      // Back-to-back dependency r3 = 5+7, r4 = r3+r3
      load(6'd1, 32'd5, 0, low);
      load(6'd2, 32'd7, 0, low);
      uop(OP_ADD, 6'd1, 6'd2, 6'd3, 1'b1, 32'd12);
      issue(OP_ADD, 6'd3, 6'd3, 6'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd24, s);
      chk("dep_stall", 32'(s), 32'(DEP_STALL));
      chk("add_psr_held", 32'(psr), 32'b0100);
      idle(2);
      uop(OP_PASS_A, 6'd4, 6'd0, 6'd0, 1'b0, 32'd24);

      // Load stall with a dependent uop in the release cycle
      load(6'd6, 32'hDEAD_BEEF, 3, low);
      chk("load_ready_low", 32'(low), 32'd3);
      issue(OP_PASS_A, 6'd6, 6'd0, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, s);
      chk("load_use_stall", 32'(s), 32'(DEP_STALL));
      uop(OP_PASS_A, 6'd6, 6'd0, 6'd0, 1'b0, 32'hDEAD_BEEF);

      // Shifts, ORNCC flags, undefined opcode
      uop(OP_SLL, 6'd1, 6'd2, 6'd0, 1'b0, 32'h0000_0280);
      uop(OP_SRL, 6'd6, 6'd2, 6'd0, 1'b0, 32'h01BD_5B7D);
      uop(OP_ORNCC, 6'd0, 6'd0, 6'd0, 1'b0, 32'hFFFF_FFFF);
      chk("orncc_psr", 32'(psr), 32'b1000);
      uop(OP_BAD, 6'd1, 6'd2, 6'd0, 1'b0, 32'd0);

      // Out-of-range (40 aliases r8 in 5 bits) and r0 writes are dropped
      uop(OP_INC, 6'd0, 6'd0, 6'd40, 1'b1, 32'd1);
      uop(OP_PASS_A, 6'd40, 6'd0, 6'd0, 1'b0, 32'd0);
      uop(OP_INC, 6'd0, 6'd0, 6'd0, 1'b1, 32'd1);
      uop(OP_PASS_A, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0);
      uop(OP_PASS_A, 6'd8, 6'd0, 6'd0, 1'b0, 32'hDEAD_BEEF);
      idle(2);

      // IR load coincident with accept: old fields used, then new ones
      w1 = (32'd10 << 25) | (32'd1 << 14) | 32'd2;
      w2 = (32'd2 << 30) | (32'd11 << 25) | (32'd2 << 19) | (32'd3 << 14) | (32'd1 << 13) | 32'd4;
      ir_load = 1'b1; ir_data = w1;
      idle(1);
      ir_data = w2;
      issue(OP_ADD, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd12, s);
      ir_load = 1'b0;
      chk("ir_op", 32'(ir_op), 32'h82);
      chk("ir13", 32'(ir13), 32'd1);
      issue(OP_ADD, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd36, s);
      uop(OP_PASS_A, 6'd10, 6'd0, 6'd0, 1'b0, 32'd12);
      uop(OP_PASS_A, 6'd11, 6'd0, 6'd0, 1'b0, 32'd36);
      idle(3);

      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/udatapath_pipe.md
Name: udatapath_pipe

Overview:
- Parametrised two-stage successor to the single-cycle microarchitecture datapath.
- Contains an IR register, a register file with r0 hardwired to zero, the ALU, operand-address muxes A/B/C (MIR field or IR field), the result/memory mux and a registered PSR condition-code latch.
- Stages: EX (operand read plus ALU, registered) and WB (register-file write).
- Micro-ops arrive from the control unit through a valid/ready handshake. Loads stall WB until data memory answers.

Parameters:
- DATAWIDTH_BUS, 32, data path width.
- REG_COUNT, 32, register-file depth; address width REG_ADDR_W = $clog2(REG_COUNT).
- DATAWIDTH_BUS_REG_MIR_FIELD, 6, MIR register-address field width; must be >= REG_ADDR_W.
- DATAWIDTH_ALU_SELECTION, 4, ALU opcode width.
- DATAWIDTH_BUS_REG_IR_OP, 8, width of the op field exported to control ({IR[31:30], IR[24:19]}).

Ports:
- uDataPathPipe_CLOCK_50  in  1  single clock, rising edge.
- uDataPathPipe_RESET_InLow  in  1  asynchronous, active-low reset.
- uDataPathPipe_IR_Load_In  in  1  load IR from IR_Data_In at the clock edge.
- uDataPathPipe_IR_Data_In  in  DATAWIDTH_BUS  instruction word.
- uDataPathPipe_Uop_Valid_In  in  1  micro-op present.
- uDataPathPipe_Uop_Ready_Out  out  1  datapath can accept a micro-op.
- uDataPathPipe_ALU_Selection_In  in  DATAWIDTH_ALU_SELECTION  ALU opcode.
- uDataPathPipe_MUX_A_MIR / _B_MIR / _C_MIR  in  DATAWIDTH_BUS_REG_MIR_FIELD  MIR register addresses.
- uDataPathPipe_MUX_A/_B/_C_MIR_Selector  in  1 each  0 = IR field (rs1/rs2/rd), 1 = MIR field.
- uDataPathPipe_RegWrite_In  in  1  uop writes its C destination.
- uDataPathPipe_MemRead_In  in  1  uop is a load: WB takes memory data, not the ALU result.
- uDataPathPipe_DataMemory_Data_In  in  DATAWIDTH_BUS  load data.
- uDataPathPipe_DataMemory_Valid_In  in  1  load data valid.
- uDataPathPipe_Result_Out  out  DATAWIDTH_BUS  WB-stage value (ALU result or load data); used as memory address/store data.
- uDataPathPipe_Result_Valid_Out  out  1  WB stage holds a completed value.
- uDataPathPipe_Reg_IR_OP  out  DATAWIDTH_BUS_REG_IR_OP  op field from IR.
- uDataPathPipe_Reg_IR_IR13  out  1  IR[13].
- uDataPathPipe_PSR_NZVC_Out  out  4  registered condition codes {N,Z,V,C}.

Behaviour:
- **Reset** (async, RESET_InLow=0): IR, register file, PSR and WB stage all clear to 0. Ready_Out=1, Result_Valid_Out=0, Result_Out=0. A pending load is discarded. Deassertion takes effect at the next edge.
- **IR**
  - Field positions: rs1=IR[18:14], rs2=IR[4:0], rd=IR[29:25], IR13=IR[13]; IR-field addresses are zero-extended.
  - If IR_Load and uop accept occur in the same cycle, the uop uses the old IR.
- **Accept**
  - A uop is accepted at an edge when Valid_In && Ready_Out.
  - A and B are read combinationally. An address >= REG_COUNT, or address 0, reads 0.
  - The ALU result, C address, RegWrite and MemRead are registered into WB at the accept edge.
- **PSR**: updated at the accept edge for cc opcodes (ADDCC, ANDCC, ORCC, ORNCC); held otherwise.
- **WB, non-load**: the register file is written at the next edge; Result_Valid_Out=1 for exactly that cycle unless another uop is accepted back-to-back.
- **WB, load**
  - WB holds; Result_Valid_Out=0 and Ready_Out=0 until DataMemory_Valid_In=1.
  - In the mem-valid cycle: Result_Out = memory data, Result_Valid_Out=1, Ready_Out=1, write at that edge.
- **Forwarding**: when a read address equals the WB destination with RegWrite=1 and the address is nonzero, the read returns the WB value (or memory data on the mem-valid cycle). WB takes priority over the register file.
- **Writes**: to address 0 or >= REG_COUNT are dropped; Result_Valid_Out still pulses.
- **Throughput**: 1 uop/cycle absent loads. Load-to-use costs only the memory wait.
- **ALU** (wrap-around at DATAWIDTH_BUS):
  - Ops: ADD(0) ADDCC(1) AND(2) ANDCC(3) OR(4) ORCC(5) ORNCC(6) SRL(7) SLL(8) INC(9) PASS_A(10); others give 0.
  - SRL/SLL shift amount is B[4:0].
  - V = signed add overflow, C = carry out; logic ops clear V and C.

Optional Feature:
- Macro: UDATAPATH_PIPE_FORWARD_EN.
- Defined: bypass as above.
- Undefined: no bypass. An EX read matching the WB destination (RegWrite, nonzero) drops Ready_Out until the write completes: one bubble for ALU ops, memory wait plus one cycle for loads.

Decomposition:
- Package udatapath_pipe_pkg: ALU opcode localparams, PSR bit indices, IR field position constants.
- One sub-module udatapath_pipe_alu: combinational, result plus NZVC plus set-flags output.
- Register file and pipeline stay in the top.

Test Plan:
- Reset mid-load:
  - Stimulus: load pending, assert RESET_InLow=0.
  - Required: Ready_Out=1 immediately, Result_Valid_Out=0, r5 reads 0 afterwards.
- ADDCC overflow:
  - Stimulus: r1=0x7FFFFFFF, r2=1.
  - Required: Result 0x80000000, PSR NZVC=1010.
  - Follow-up: then ORCC r0,r0 → NZVC=0100.
- Back-to-back dependency:
  - Stimulus: ADD r3=r1+r2 (5+7), then next cycle ADD r4=r3+r3.
  - Required: r4=24. With FORWARD_EN there is no stall; without it, Ready_Out is low for 1 cycle.
- Load stall:
  - Stimulus: MemRead to r6, DataMemory_Valid_In after 3 cycles with 0xDEADBEEF.
  - Required: Ready_Out low for 3 cycles, r6=0xDEADBEEF, a dependent uop in the release cycle reads 0xDEADBEEF.
- Out-of-range and r0 writes:
  - Stimulus: MIR C address 40 with REG_COUNT=32, and a write to r0.
  - Required: Result_Valid_Out pulses, no register changes, reads of r0 return 0.
- IR load plus accept:
  - Stimulus: IR load and uop accept in the same cycle with selector=0.
  - Required: the uop uses the old rs1/rs2/rd; the next uop uses the new IR.
